// File: rtl/bcd_timer_counter.sv
// Cascaded multi-digit BCD up/down counter with optional mm:ss digit and saturation.
// Latency: count and done update one clock after the qualifying inputs; tc/zero are combinational from count.
// Backpressure: none; en gates counting, loadn loads, clear resets; inputs are acted on every cycle.
module bcd_timer_counter #(
    parameter int DIGITS   = 4,
    parameter int SEC_MODE = 1,
    parameter int SATURATE = 1
) (
    input  logic                  clock,
    input  logic                  clear,
    input  logic                  en,
    input  logic                  loadn,
    input  logic                  up,
    input  logic [4*DIGITS-1:0]   data,
    output logic [4*DIGITS-1:0]   count,
    output logic                  tc,
    output logic                  zero,
    output logic                  done
);

    // Largest legal value for digit i: tens-of-seconds digit is mod-6 in mm:ss mode.
    function automatic logic [3:0] digit_max(input int i);
        if ((SEC_MODE != 0) && (DIGITS > 1) && (i == 1)) return 4'd5;
        return 4'd9;
    endfunction

    logic [4*DIGITS-1:0] max_val;     // all digits at their maximum (up terminal)
    logic [4*DIGITS-1:0] load_val;    // data with each digit clamped to its maximum
    logic [4*DIGITS-1:0] step_val;    // count after one ripple step in direction up
    logic [4*DIGITS-1:0] count_step;  // step_val, or count when saturated at terminal
    logic                at_term;     // count is terminal for the current direction
    logic                arrive;      // this step moves count from non-terminal to terminal
    logic                pending;     // terminal reached on previous edge; done fires next

    // Build the all-max constant and the clamped load value.
    always_comb begin
        max_val  = '0;
        load_val = '0;
        for (int i = 0; i < DIGITS; i++) begin
            max_val[4*i +: 4]  = digit_max(i);
            load_val[4*i +: 4] = (data[4*i +: 4] > digit_max(i)) ? digit_max(i) : data[4*i +: 4];
        end
    end

    // Ripple carry/borrow chain: a digit moves only when every lower digit is at its wrap point.
    always_comb begin
        logic       chain;
        logic [3:0] d;
        step_val = count;
        chain    = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            d = count[4*i +: 4];
            if (chain) begin
                if (up) step_val[4*i +: 4] = (d == digit_max(i)) ? 4'd0 : 4'(d + 4'd1);
                else    step_val[4*i +: 4] = (d == 4'd0) ? digit_max(i) : 4'(d - 4'd1);
            end
            chain = chain & (up ? (d == digit_max(i)) : (d == 4'd0));
        end
    end

    // Terminal detection, saturation hold and arrival detection for the done pulse.
    always_comb begin
        at_term    = up ? (count == max_val) : (count == '0);
        count_step = ((SATURATE != 0) && at_term) ? count : step_val;
        arrive     = ~at_term & (up ? (step_val == max_val) : (step_val == '0));
    end

    assign tc   = en & at_term;
    assign zero = (count == '0);

    // State update: clear > load > count > hold; load, clear and idle cycles abort a pending done.
    always_ff @(posedge clock) begin
        if (clear) begin
            count   <= '0;
            done    <= 1'b0;
            pending <= 1'b0;
        end else if (!loadn) begin
            count   <= load_val;
            done    <= 1'b0;
            pending <= 1'b0;
        end else if (en) begin
            count   <= count_step;
            done    <= pending;
            pending <= arrive;
        end else begin
            done    <= 1'b0;
            pending <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bcd_timer_counter.sv
// Scoreboard bench for two configurations: 4-digit mm:ss saturating, and 2-digit decimal wrapping.
// Expected outputs per edge are pushed by the driver; a monitor pops and compares after each edge.
// Reference model tracks the count as a plain integer in mixed radix.
module tb_bcd_timer_counter;

    logic        clock = 1'b0;
    logic        clear = 1'b1;
    logic        en    = 1'b0;
    logic        loadn = 1'b1;
    logic        up    = 1'b0;
    logic [31:0] data  = '0;

    logic [15:0] count_a;
    logic        tc_a, zero_a, done_a;
    logic [7:0]  count_b;
    logic        tc_b, zero_b, done_b;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    bcd_timer_counter #(.DIGITS(4), .SEC_MODE(1), .SATURATE(1)) dut_a (
        .clock(clock), .clear(clear), .en(en), .loadn(loadn), .up(up),
        .data(data[15:0]), .count(count_a), .tc(tc_a), .zero(zero_a), .done(done_a)
    );

    bcd_timer_counter #(.DIGITS(2), .SEC_MODE(0), .SATURATE(0)) dut_b (
        .clock(clock), .clear(clear), .en(en), .loadn(loadn), .up(up),
        .data(data[7:0]), .count(count_b), .tc(tc_b), .zero(zero_b), .done(done_b)
    );

    typedef struct {
        logic [15:0] cnt_a;
        logic        tc_a, zero_a, done_a;
        logic [7:0]  cnt_b;
        logic        tc_b, zero_b, done_b;
        int          idx;
    } exp_t;

    exp_t exp_q[$];

    // ---------------- reference model ----------------
    function automatic int radix(input int i, input int nd, input int sec);
        return (sec != 0 && nd > 1 && i == 1) ? 6 : 10;
    endfunction

    function automatic int total(input int nd, input int sec);
        int t = 1;
        for (int i = 0; i < nd; i++) t *= radix(i, nd, sec);
        return t;
    endfunction

    // BCD load value (with clamping) to integer value.
    function automatic int load_int(input logic [31:0] d, input int nd, input int sec);
        int v = 0;
        int w = 1;
        for (int i = 0; i < nd; i++) begin
            int dig = int'(d[4*i +: 4]);
            if (dig > radix(i, nd, sec) - 1) dig = radix(i, nd, sec) - 1;
            v += dig * w;
            w *= radix(i, nd, sec);
        end
        return v;
    endfunction

    function automatic logic [31:0] to_bcd(input int v, input int nd, input int sec);
        logic [31:0] r = '0;
        int x = v;
        for (int i = 0; i < nd; i++) begin
            r[4*i +: 4] = 4'(x % radix(i, nd, sec));
            x = x / radix(i, nd, sec);
        end
        return r;
    endfunction

    task automatic model_step(input int nd, input int sec, input int sat,
                              input logic cl, input logic ld_n, input logic e, input logic u,
                              input logic [31:0] d,
                              inout int v, inout logic dn, inout logic pd);
        int top = total(nd, sec) - 1;
        int term = u ? top : 0;
        if (cl) begin
            v = 0; dn = 1'b0; pd = 1'b0;
        end else if (!ld_n) begin
            v = load_int(d, nd, sec); dn = 1'b0; pd = 1'b0;
        end else if (e) begin
            dn = pd;
            if (v == term) begin
                if (sat == 0) v = u ? 0 : top;
                pd = 1'b0;
            end else begin
                v = u ? v + 1 : v - 1;
                pd = (v == term);
            end
        end else begin
            dn = 1'b0; pd = 1'b0;
        end
    endtask

    int   va = 0, vb = 0;
    logic da = 1'b0, pa = 1'b0, db = 1'b0, pb = 1'b0;
    int   n_issued = 0;

    // Drive one cycle of inputs and push the expected post-edge outputs.
    task automatic cyc(input logic cl, input logic ld_n, input logic e, input logic u,
                       input logic [31:0] d);
        exp_t x;
        @(negedge clock);
        clear = cl; loadn = ld_n; en = e; up = u; data = d;
        model_step(4, 1, 1, cl, ld_n, e, u, d, va, da, pa);
        model_step(2, 0, 0, cl, ld_n, e, u, d, vb, db, pb);
        x.cnt_a  = 16'(to_bcd(va, 4, 1));
        x.zero_a = (va == 0);
        x.tc_a   = e && (va == (u ? total(4, 1) - 1 : 0));
        x.done_a = da;
        x.cnt_b  = 8'(to_bcd(vb, 2, 0));
        x.zero_b = (vb == 0);
        x.tc_b   = e && (vb == (u ? total(2, 0) - 1 : 0));
        x.done_b = db;
        x.idx    = n_issued;
        n_issued++;
        exp_q.push_back(x);
    endtask

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, idx, act, req);
        end
    endtask

    // Monitor: after each edge compare DUT outputs with the oldest expectation.
    initial begin
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() > 0) begin
                exp_t x;
                x = exp_q.pop_front();
                check("count_a", x.idx, 32'(count_a), 32'(x.cnt_a));
                check("tc_a",    x.idx, 32'(tc_a),    32'(x.tc_a));
                check("zero_a",  x.idx, 32'(zero_a),  32'(x.zero_a));
                check("done_a",  x.idx, 32'(done_a),  32'(x.done_a));
                check("count_b", x.idx, 32'(count_b), 32'(x.cnt_b));
                check("tc_b",    x.idx, 32'(tc_b),    32'(x.tc_b));
                check("zero_b",  x.idx, 32'(zero_b),  32'(x.zero_b));
                check("done_b",  x.idx, 32'(done_b),  32'(x.done_b));
            end
        end
    end

    // Stimulus: directed scenarios followed by randomized traffic.
    initial begin
        logic       r_up;
        logic [31:0] r_dat;
        int          sel;

        // Reset, then enabled down-count holding at zero.
        cyc(1, 1, 0, 0, 32'h0);
        repeat (3) cyc(0, 1, 1, 0, 32'h0);

        // 01:00 down to 00:00, done pulse, then hold.
        cyc(0, 0, 1, 0, 32'h0000_0100);
        repeat (64) cyc(0, 1, 1, 0, 32'h0);

        // Clamped load, then up to saturation.
        cyc(0, 0, 0, 1, 32'h0000_1979);
        cyc(0, 0, 0, 1, 32'h0000_9958);
        repeat (4) cyc(0, 1, 1, 1, 32'h0);
        cyc(0, 0, 0, 1, 32'h0000_FCFC);

        // Clear beats load; load beats count.
        cyc(1, 0, 1, 0, 32'h0000_1234);
        cyc(0, 0, 1, 0, 32'h0000_0001);
        cyc(0, 0, 1, 0, 32'h0000_0005);

        // Pause and resume mid-count.
        cyc(0, 0, 1, 0, 32'h0000_0032);
        repeat (2) cyc(0, 1, 1, 0, 32'h0);
        repeat (2) cyc(0, 1, 0, 0, 32'h0);
        repeat (2) cyc(0, 1, 1, 0, 32'h0);

        // Wrap behaviour around zero / all-nines, and direction change.
        cyc(0, 0, 1, 0, 32'h0);
        repeat (3) cyc(0, 1, 1, 0, 32'h0);
        repeat (4) cyc(0, 1, 1, 1, 32'h0);
        cyc(0, 0, 0, 1, 32'h0000_0003);
        repeat (5) cyc(0, 1, 1, 0, 32'h0);

        // Randomized traffic.
        r_up = 1'b0;
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 29) == 0) r_up = ~r_up;
            sel = int'($urandom_range(0, 2));
            case (sel)
                0:       r_dat = $urandom;
                1:       r_dat = $urandom & 32'h0000_00FF;
                default: r_dat = 32'h0000_9950 | ($urandom & 32'hF);
            endcase
            cyc($urandom_range(0, 199) == 0,
                $urandom_range(0, 39) != 0,
                $urandom_range(0, 9) != 0,
                r_up, r_dat);
        end

        repeat (3) @(negedge clock);
        check("queue_drained", n_issued, 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
